// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants, count type and window helper,
// imported by the timing generator and by the pixel/object renderers.
package vga_timing_pkg;

  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam int unsigned H_ACT_START = H_SYNC + H_BP;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE - 1;
  localparam int unsigned V_ACT_START = V_SYNC + V_BP;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE - 1;

  typedef logic [9:0] count_t;

  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic bright;
  } sync_t;

  function automatic logic in_span(count_t c, count_t lo, count_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, h/v counters, sync/bright decode,
// frame_start and game_tick strobes. Define VGA_TIMING_REG_OUT_EN to register
// hSync/vSync/bright (glitch-free pins, same alignment to hCount/vCount).
module vga_timing_gen #(
  parameter int unsigned PIX_DIV     = 4,
  parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP        = vga_timing_pkg::H_BP,
  parameter int unsigned H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP        = vga_timing_pkg::H_FP,
  parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP        = vga_timing_pkg::V_BP,
  parameter int unsigned V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP        = vga_timing_pkg::V_FP,
  parameter int unsigned TICK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       bright,
  output logic       hSync,
  output logic       vSync,
  output logic       pix_en,
  output logic       frame_start,
  output logic       game_tick
);
  import vga_timing_pkg::*;

  localparam count_t H_LAST     = count_t'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam count_t V_LAST     = count_t'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);
  localparam count_t H_SYNC_END = count_t'(H_SYNC);
  localparam count_t V_SYNC_END = count_t'(V_SYNC);
  localparam count_t H_LO       = count_t'(H_SYNC + H_BP);
  localparam count_t H_HI       = count_t'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam count_t V_LO       = count_t'(V_SYNC + V_BP);
  localparam count_t V_HI       = count_t'(V_SYNC + V_BP + V_ACTIVE - 1);

  localparam int unsigned FC_W = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(TICK_FRAMES - 1);

  logic            pix_en_w;
  count_t          hcount_q, hcount_d;
  count_t          vcount_q, vcount_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            frame_start_q, frame_start_d;
  logic            game_tick_q, game_tick_d;
  logic            h_wrap, frame_wrap;
  sync_t           sync;

  // With PIX_DIV == 1 there is no divider state at all; pix_en is tied high.
  if (PIX_DIV > 1) begin : g_div
    localparam int unsigned DIV_W = $clog2(PIX_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) div_q <= '0;
      else     div_q <= div_d;
    end

    assign pix_en_w = (div_q == DIV_LAST);
  end else begin : g_nodiv
    assign pix_en_w = 1'b1;
  end

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_cnt_d   = frame_cnt_q;
    h_wrap        = pix_en_w && (hcount_q == H_LAST);
    frame_wrap    = h_wrap && (vcount_q == V_LAST);
    frame_start_d = frame_wrap;
    game_tick_d   = frame_wrap && (frame_cnt_q == FC_LAST);
    if (pix_en_w) hcount_d = h_wrap ? '0 : hcount_q + count_t'(1);
    if (h_wrap)   vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + count_t'(1);
    if (frame_wrap) begin
      frame_cnt_d = (frame_cnt_q == FC_LAST) ? '0 : frame_cnt_q + FC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
      game_tick_q   <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
      game_tick_q   <= game_tick_d;
    end
  end

  function automatic sync_t decode(count_t h, count_t v);
    sync_t s;
    s.h_sync = ~(h < H_SYNC_END);
    s.v_sync = ~(v < V_SYNC_END);
    s.bright = in_span(h, H_LO, H_HI) && in_span(v, V_LO, V_HI);
    return s;
  endfunction

`ifdef VGA_TIMING_REG_OUT_EN
  // Decoding the next-state counts keeps the registered pins aligned with hCount/vCount.
  sync_t sync_q, sync_d;

  always_comb begin
    sync_d = decode(hcount_d, vcount_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign sync = sync_q;
`else
  always_comb begin
    sync = decode(hcount_q, vcount_q);
  end
`endif

  assign hCount      = hcount_q;
  assign vCount      = vcount_q;
  assign pix_en      = pix_en_w;
  assign hSync       = sync.h_sync;
  assign vSync       = sync.v_sync;
  assign bright      = sync.bright;
  assign frame_start = frame_start_q;
  assign game_tick   = game_tick_q;

endmodule
